gmii_rx_frame_check: RTL and testbench

//  Ethernet receive front-end on the GMII side, directly upstream of the 8b->64b AXI packer.

---
 rtl/gmii_rx_frame_check.sv | 156 +++++++++++++++
 tb/tb_gmii_rx_frame_check.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_frame_check.sv
// rtl/gmii_rx_frame_check.sv - GMII receive framer: preamble strip, FCS/length check, FCS strip, stats
//
// Purpose: strips the preamble and SFD from a GMII receive stream. Checks the frame's
//   CRC-32 and its length, then forwards DA..last payload byte as an 8-bit stream. The
//   frame's error flag is carried on the tlast beat. Keeps saturating good/bad/drop counters.
// Ports:
//   gmii_rx_clk            receive clock; the whole block runs in this domain
//   sys_rst                synchronous active-high reset
//   gmii_rx_dv, gmii_rxd   GMII receive data valid and byte
//   m_axis_t*              payload stream (no backpressure); tuser = frame error on tlast
//   stat_good/bad/drop     saturating frame counters
`timescale 1ns/1ps
module gmii_rx_frame_check #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter int CNT_W     = 16
) (
  input  logic             gmii_rx_clk,
  input  logic             sys_rst,
  input  logic             gmii_rx_dv,
  input  logic [7:0]       gmii_rxd,
  output logic             m_axis_tvalid,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  output logic [CNT_W-1:0] stat_good,
  output logic [CNT_W-1:0] stat_bad,
  output logic [CNT_W-1:0] stat_drop
);

  localparam int LEN_W = $clog2(MAX_FRAME + 2);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_FRAME + 1);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_FRAME);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_FRAME);
  localparam logic [LEN_W-1:0] LEN_FCS = LEN_W'(5);
  localparam logic [31:0]      CRC_RESIDUE = 32'hC704DD7B;

  typedef enum logic [1:0] {IDLE, PRE, DATA, ABORT} state_t;

  state_t            r_state;
  logic              r_dv_d;
  logic [4:0][7:0]   r_sr;
  logic [LEN_W-1:0]  r_cnt;
  logic [31:0]       r_crc;

  logic [31:0]       w_crc_next;
  logic [31:0]       w_crc_rev;
  logic              w_start;
  logic              w_err;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] v;
    v = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
    end
    return v;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // The register is kept in reflected (LSB-first) order. It is bit-reversed here so that
  // the residue comparison is made in normal bit order.
  always_comb begin
    w_crc_rev = '0;
    for (int i = 0; i < 32; i++) begin
      w_crc_rev[i] = r_crc[31-i];
    end
  end

  assign w_crc_next = crc_byte(r_crc, gmii_rxd);
  assign w_start    = gmii_rx_dv & ~r_dv_d;
  assign w_err      = (w_crc_rev != CRC_RESIDUE) | (r_cnt < LEN_MIN) | (r_cnt > LEN_MAX);

  always_ff @(posedge gmii_rx_clk) begin
    // dv history keeps tracking through reset. This way, a dv already high at release is
    // not seen as a rising edge.
    r_dv_d <= gmii_rx_dv;
    if (sys_rst) begin
      r_state       <= IDLE;
      r_sr          <= '0;
      r_cnt         <= '0;
      r_crc         <= '1;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 8'h00;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      stat_good     <= '0;
      stat_bad      <= '0;
      stat_drop     <= '0;
    end else begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_cnt <= '0;
            r_crc <= '1;
            if (gmii_rxd == 8'h55) begin
              r_state <= PRE;
            end else if (gmii_rxd == 8'hD5) begin
              r_state <= DATA;
            end else begin
              r_state   <= ABORT;
              stat_drop <= sat_inc(stat_drop);
            end
          end
        end
        PRE: begin
          if (!gmii_rx_dv) begin
            r_state   <= IDLE;
            stat_drop <= sat_inc(stat_drop);
          end else if (gmii_rxd == 8'hD5) begin
            r_state <= DATA;
          end else if (gmii_rxd != 8'h55) begin
            r_state   <= ABORT;
            stat_drop <= sat_inc(stat_drop);
          end
        end
        DATA: begin
          if (gmii_rx_dv) begin
            r_sr  <= {r_sr[3:0], gmii_rxd};
            r_crc <= w_crc_next;
            if (r_cnt != LEN_SAT) r_cnt <= r_cnt + LEN_W'(1);
            // The oldest byte leaves only once four newer bytes are behind it. Those
            // trailing four may turn out to be the FCS.
            if (r_cnt >= LEN_FCS) begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= r_sr[4];
            end
          end else begin
            r_state <= IDLE;
            if (r_cnt >= LEN_FCS) begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= r_sr[4];
              m_axis_tlast  <= 1'b1;
              m_axis_tuser  <= w_err;
              if (w_err) stat_bad  <= sat_inc(stat_bad);
              else       stat_good <= sat_inc(stat_good);
            end else begin
              stat_drop <= sat_inc(stat_drop);
            end
          end
        end
        ABORT: begin
          if (!gmii_rx_dv) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_frame_check.sv
// tb/tb_gmii_rx_frame_check.sv - scoreboard bench for gmii_rx_frame_check
`timescale 1ns/1ps
module tb_gmii_rx_frame_check;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             dv;
  logic [7:0]       rxd;
  logic             tvalid;
  logic [7:0]       tdata;
  logic             tlast;
  logic             tuser;
  logic [CNT_W-1:0] s_good;
  logic [CNT_W-1:0] s_bad;
  logic [CNT_W-1:0] s_drop;

  always #4 clk = ~clk;

  gmii_rx_frame_check #(.MIN_FRAME(64), .MAX_FRAME(1518), .CNT_W(CNT_W)) dut (
    .gmii_rx_clk   (clk),
    .sys_rst       (rst),
    .gmii_rx_dv    (dv),
    .gmii_rxd      (rxd),
    .m_axis_tvalid (tvalid),
    .m_axis_tdata  (tdata),
    .m_axis_tlast  (tlast),
    .m_axis_tuser  (tuser),
    .stat_good     (s_good),
    .stat_bad      (s_bad),
    .stat_drop     (s_drop)
  );

  typedef struct {
    logic [7:0] d;
    logic       last;
    logic       user;
    int         at;
  } exp_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  exp_t       expq[$];
  exp_t       e;
  logic [7:0] fr[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every beat the DUT presents must match the head of the expected queue,
  // including the clock cycle it was due.
  always @(posedge clk) begin
    #1;
    if (tvalid === 1'b1) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got data=%h last=%b at cyc %0d, required no beat", tdata, tlast, cyc);
      end else begin
        e = expq.pop_front();
        if (tdata !== e.d || tlast !== e.last || (e.last && tuser !== e.user) || cyc != e.at) begin
          errors++;
          $display("FAIL beat: got data=%h last=%b user=%b cyc=%0d, required data=%h last=%b user=%b cyc=%0d",
                   tdata, tlast, tuser, cyc, e.d, e.last, e.user, e.at);
        end
      end
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] v;
    v = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
    return v;
  endfunction

  // Builds plen payload bytes, then appends the Ethernet FCS (complemented CRC, LSB first).
  task automatic make_frame(input int plen, input int seed);
    logic [31:0] c;
    fr.delete();
    for (int i = 0; i < plen; i++) fr.push_back(8'(seed + i * 7));
    c = 32'hFFFFFFFF;
    foreach (fr[i]) c = crc_upd(c, fr[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
  endtask

  task automatic drive(input logic d, input logic [7:0] b);
    @(negedge clk);
    dv  = d;
    rxd = b;
  endtask

  // Sends npre preamble bytes, then sfd, then fr. Each payload byte is expected 5 clocks
  // after the edge that samples it.
  task automatic tx(input int npre, input logic [7:0] sfd, input bit exp_err, input int gap);
    int n;
    exp_t x;
    n = fr.size();
    for (int i = 0; i < npre; i++) drive(1'b1, 8'h55);
    drive(1'b1, sfd);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, fr[i]);
      if (n >= 5 && i < n - 4) begin
        x.d = fr[i]; x.last = (i == n - 5); x.user = exp_err; x.at = cyc + 6;
        expq.push_back(x);
      end
    end
    for (int i = 0; i < gap; i++) drive(1'b0, 8'h00);
  endtask

  task automatic check_stats(input string tag, input int g, input int b, input int d);
    check({tag, "_good"}, s_good, g);
    check({tag, "_bad"},  s_bad,  b);
    check({tag, "_drop"}, s_drop, d);
  endtask

  initial begin
    exp_t x;
    int   wait_n;
    rst = 1'b1; dv = 1'b0; rxd = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast",  tlast,  0);
    check("rst_tuser",  tuser,  0);
    check("rst_tdata",  tdata,  0);
    check_stats("rst", 0, 0, 0);
    rst = 1'b0;
    repeat (2) drive(1'b0, 8'h00);

    // 1: good 64-byte frame
    make_frame(60, 1);
    tx(7, 8'hD5, 1'b0, 4);
    check_stats("t1", 1, 0, 0);

    // 2: one payload bit flipped
    make_frame(60, 1);
    fr[10] = fr[10] ^ 8'h04;
    tx(7, 8'hD5, 1'b1, 4);
    check_stats("t2", 1, 1, 0);

    // 3: runt with valid FCS (no preamble), then 1519-byte oversize frame
    make_frame(40, 2);
    tx(0, 8'hD5, 1'b1, 4);
    check_stats("t3a", 1, 2, 0);
    make_frame(1515, 4);
    tx(7, 8'hD5, 1'b1, 4);
    check_stats("t3b", 1, 3, 0);

    // 4: bad preamble byte, then dv drop after 3 DATA bytes
    drive(1'b1, 8'h55); drive(1'b1, 8'h55); drive(1'b1, 8'h12);
    drive(1'b1, 8'hAA); drive(1'b1, 8'hBB);
    repeat (4) drive(1'b0, 8'h00);
    check_stats("t4a", 1, 3, 1);
    fr.delete();
    fr.push_back(8'h01); fr.push_back(8'h02); fr.push_back(8'h03);
    tx(7, 8'hD5, 1'b0, 4);
    check_stats("t4b", 1, 3, 2);

    // 5: back-to-back frames with a one-cycle dv gap
    make_frame(60, 5);
    tx(7, 8'hD5, 1'b0, 1);
    make_frame(60, 9);
    tx(7, 8'hD5, 1'b0, 4);
    check_stats("t5", 3, 3, 2);

    // 6: reset mid-payload with dv held high
    make_frame(60, 11);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, fr[i]);
      if (i < 15) begin
        x.d = fr[i]; x.last = 1'b0; x.user = 1'b0; x.at = cyc + 6;
        expq.push_back(x);
      end
    end
    @(negedge clk);
    rst = 1'b1; dv = 1'b1; rxd = fr[20];
    @(posedge clk);
    #1;
    check("t6_tvalid_after_rst", tvalid, 0);
    check("t6_tlast_after_rst",  tlast,  0);
    drive(1'b1, 8'h55);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h55);
    repeat (4) drive(1'b0, 8'h00);
    check_stats("t6_rst", 0, 0, 0);
    make_frame(60, 13);
    tx(7, 8'hD5, 1'b0, 4);
    check_stats("t6_after", 1, 0, 0);

    wait_n = 0;
    while (expq.size() != 0 && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check("expected_beats_left", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
